display_scan_mux: RTL

Time-multiplexed scan driver for a multi-digit seven-segment display. It latches a packed multi-digit BCD value and cycles through the digits at a programmable refresh rate. Each cycle it presents one 4-bit digit code to the per-digit BCD-to-segment decoder, together with a one-hot digit enable. It sits directly upstream of that decoder. New values are committed only at frame boundaries, so a scan never shows a mix of old and new digits.

---
 rtl/seg_display_pkg.sv | 15 +
 rtl/refresh_tick_gen.sv | 35 +++
 rtl/display_scan_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg
//   Constants shared by the seven-segment scan driver and the downstream
//   BCD-to-segment decoder.
//     DIGIT_W    : width of one digit code (BCD nibble)
//     BLANK_CODE : code the decoder renders as an unlit digit
//     MAX_DIGITS : largest supported display width
package seg_display_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen
//   Free-running prescaler. Counts 0..REFRESH_DIV-1 and asserts tick
//   during the last count, then restarts from 0.
//   Parameters:
//     REFRESH_DIV : period of tick in clock cycles (>= 1; 1 = every cycle)
//   Ports:
//     Clk  : clock, rising edge
//     Rst  : synchronous active-high reset, clears the count
//     tick : high while the count equals REFRESH_DIV-1
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);

  // A divider of 1 still needs one register bit; it simply stays at 0.
  localparam int W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [W-1:0] presc;

  assign tick = (presc == W'(REFRESH_DIV - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + W'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed scan driver for a multi-digit seven-segment display.
//   A loaded value is held in a shadow register and only copied to the
//   displayed register when the scan wraps from the last digit to digit 0,
//   so one frame never mixes old and new digits.
//   Parameters:
//     DIGITS      : number of digits (1..8)
//     REFRESH_DIV : cycles each digit stays enabled (>= 1)
//   Ports:
//     Clk         : clock, rising edge
//     Rst         : synchronous active-high reset
//     Load        : one-cycle strobe capturing Value
//     Value       : packed digit codes, nibble k = digit k (digit 0 is LSD)
//     Data        : registered digit code for the decoder
//     Digit_En    : registered one-hot digit select
//     Frame_Start : one-cycle pulse when digit 0 is re-enabled after a wrap
//   Build option:
//     LEADING_ZERO_BLANK_EN : when defined, zero digits above the most
//                             significant non-zero digit show BLANK_CODE
//                             (digit 0 is always shown).
//   Handshake: no valid/ready. Load is a fire-and-forget strobe accepted in
//   every non-reset cycle; the outputs are valid every cycle after reset.
module display_scan_mux
  import seg_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] Value,
  output logic [DIGIT_W-1:0]        Data,
  output logic [DIGITS-1:0]         Digit_En,
  output logic                      Frame_Start
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = DIGIT_W * DIGITS;

  logic          tick;
  logic          wrap;
  logic [IW-1:0] idx;
  logic [VW-1:0] shadow;
  logic [VW-1:0] disp;
  logic          pending;
  // Set for the one cycle in which idx has just returned to 0.
  logic          wrapped;

  digit_t              data_next;
  logic [DIGITS-1:0]   en_next;

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (tick)
  );

  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Scan position and frame-synchronous value commit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + IW'(1);
      end
      if (wrap) begin
        // A Load coinciding with the wrap bypasses the shadow register.
        if (Load) begin
          disp <= Value;
        end else if (pending) begin
          disp <= shadow;
        end
        pending <= 1'b0;
      end else if (Load) begin
        shadow  <= Value;
        pending <= 1'b1;
      end
    end
  end

  // Select the current digit and optional leading-zero blanking.
  always_comb begin
    data_next = '0;
    en_next   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        en_next[k] = 1'b1;
        data_next  = disp[k*DIGIT_W +: DIGIT_W];
`ifdef LEADING_ZERO_BLANK_EN
        // Digit k and everything above it are zero: it is a leading zero.
        if ((k > 0) && ((disp >> (k * DIGIT_W)) == '0)) begin
          data_next = BLANK_CODE;
        end
`endif
      end
    end
  end

  // Output register stage: outputs lag idx/disp by one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Data        <= '0;
      Digit_En    <= '0;
      Frame_Start <= 1'b0;
    end else begin
      Data        <= data_next;
      Digit_En    <= en_next;
      Frame_Start <= wrapped;
    end
  end

endmodule
